// File: rtl/dpe_dest_router.sv
// dpe_dest_router: routes one tagged ingress frame stream to CPU port 0,
// Ethernet ports 1..NUM_PORTS-1, or all ports but the source (broadcast).
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   s_valid/s_ready    ingress handshake
//   s_data/s_sof/s_eof ingress beat and framing
//   s_dst/s_src        destination/source address (sampled on sof)
//   m_valid/m_ready    per-port egress handshake (lockstep)
//   m_data/m_sof/m_eof egress beat, pass-through from ingress
//   busy               FSM is not idle
//   orphan             pulse when a non-sof beat is discarded in IDLE
//   drop_cnt           dropped-frame count, saturating
//   bcast_cnt          completed broadcast-frame count, saturating
module dpe_dest_router #(
    parameter int DW         = 8,
    parameter int NUM_PORTS  = 5,
    parameter int AW         = 3,
    parameter int BCAST_ADDR = 7
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_sof,
    input  logic                 s_eof,
    input  logic [AW-1:0]        s_dst,
    input  logic [AW-1:0]        s_src,
    output logic [NUM_PORTS-1:0] m_valid,
    input  logic [NUM_PORTS-1:0] m_ready,
    output logic [DW-1:0]        m_data,
    output logic                 m_sof,
    output logic                 m_eof,
    output logic                 busy,
    output logic                 orphan,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          bcast_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        FWD,
        DROP
    } state_t;

    localparam logic [AW-1:0] PORTS_A = AW'(NUM_PORTS);
    localparam logic [AW-1:0] BCAST_A = AW'(BCAST_ADDR);
    localparam logic [NUM_PORTS-1:0] ONE_P = NUM_PORTS'(1);
    localparam logic [NUM_PORTS-1:0] ALL_P = {NUM_PORTS{1'b1}};

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]        dst_q;
    logic [AW-1:0]        src_q;
    logic [NUM_PORTS-1:0] mask_q;
    logic                 bcast_q;
    logic [15:0]          drop_cnt_q;
    logic [15:0]          bcast_cnt_q;

    logic                 dst_uni;
    logic                 dst_bc;
    logic                 src_local;
    logic [NUM_PORTS-1:0] dst_oh;
    logic [NUM_PORTS-1:0] src_oh;
    logic [NUM_PORTS-1:0] bc_mask;
    logic [NUM_PORTS-1:0] dec_mask;
    logic                 dec_drop;

    logic sel_ready;
    logic beat;
    logic eof_beat;
    logic drop_inc;
    logic bcast_inc;

    // ---------------------------------------------------------------
    // Destination decode from the addresses latched on the sof beat
    // ---------------------------------------------------------------
    always_comb begin
        dst_uni   = dst_q < PORTS_A;
        dst_bc    = dst_q == BCAST_A;
        src_local = src_q < PORTS_A;
        dst_oh    = dst_uni ? (ONE_P << dst_q) : '0;
        src_oh    = src_local ? (ONE_P << src_q) : '0;
        bc_mask   = ALL_P & ~src_oh;
        dec_mask  = dst_bc ? bc_mask : dst_oh;
        // Self-addressed, unknown, or a broadcast reaching nobody.
        dec_drop  = (dst_q == src_q)
                  | ~(dst_uni | dst_bc)
                  | (dst_bc & (bc_mask == '0));
    end

    // Lockstep egress: only selected ports gate progress.
    assign sel_ready = &(m_ready | ~mask_q);
    assign beat      = s_valid & s_ready;
    assign eof_beat  = beat & s_eof;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_valid & s_sof) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = dec_drop ? DROP : FWD;
            end
            FWD: begin
                if (eof_beat) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (eof_beat) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        s_ready = 1'b0;
        m_valid = '0;
        orphan  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Hold the sof beat so it is forwarded after decode.
                s_ready = ~(s_valid & s_sof);
                orphan  = s_valid & ~s_sof;
            end
            DECODE: begin
                s_ready = 1'b0;
            end
            FWD: begin
                m_valid = mask_q & {NUM_PORTS{s_valid}};
                s_ready = sel_ready;
            end
            DROP: begin
                s_ready = 1'b1;
            end
        endcase
    end

    assign busy   = state_q != IDLE;
    assign m_data = s_data;
    assign m_sof  = s_sof;
    assign m_eof  = s_eof;

    // ---------------------------------------------------------------
    // Address latch and routing mask
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dst_q <= '0;
            src_q <= '0;
        end else if ((state_q == IDLE) && s_valid && s_sof) begin
            dst_q <= s_dst;
            src_q <= s_src;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mask_q  <= '0;
            bcast_q <= 1'b0;
        end else if ((state_q == DECODE) && !dec_drop) begin
            mask_q  <= dec_mask;
            bcast_q <= dst_bc;
        end else if ((state_q == FWD) && eof_beat) begin
            mask_q  <= '0;
            bcast_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Saturating statistics
    // ---------------------------------------------------------------
    assign drop_inc  = (state_q == DECODE) & dec_drop;
    assign bcast_inc = (state_q == FWD) & eof_beat & bcast_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bcast_cnt_q <= '0;
        end else if (bcast_inc && (bcast_cnt_q != 16'hFFFF)) begin
            bcast_cnt_q <= bcast_cnt_q + 16'd1;
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_dpe_dest_router.sv
// tb_dpe_dest_router: directed frames against a frame-level routing model,
// with per-cycle output comparison and literal spot checks.
module tb_dpe_dest_router;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_sof;
    logic          s_eof;
    logic [2:0]    s_dst;
    logic [2:0]    s_src;
    logic [NP-1:0] m_valid;
    logic [NP-1:0] m_ready;
    logic [7:0]    m_data;
    logic          m_sof;
    logic          m_eof;
    logic          busy;
    logic          orphan;
    logic [15:0]   drop_cnt;
    logic [15:0]   bcast_cnt;

    dpe_dest_router #(
        .DW(8), .NUM_PORTS(NP), .AW(3), .BCAST_ADDR(7)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .s_dst(s_dst), .s_src(s_src),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .orphan(orphan),
        .drop_cnt(drop_cnt), .bcast_cnt(bcast_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic          exp_ready;
    logic [NP-1:0] exp_mv;
    logic          exp_busy;
    logic          exp_orphan;
    logic [15:0]   exp_drop;
    logic [15:0]   exp_bcast;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Routing rule: {drop, bcast, mask}
    function automatic logic [NP+1:0] route(input int dst, input int src);
        logic [NP-1:0] m;
        m = '0;
        if (dst == src) return {1'b1, 1'b0, m};
        if (dst < NP) begin
            m[dst] = 1'b1;
            return {1'b0, 1'b0, m};
        end
        if (dst == 7) begin
            m = '1;
            if (src < NP) m[src] = 1'b0;
            return {(m == '0), 1'b1, m};
        end
        return {1'b1, 1'b0, m};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
            chk("m_valid", 32'(m_valid), 32'(exp_mv));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("orphan", 32'(orphan), 32'(exp_orphan));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            chk("bcast_cnt", 32'(bcast_cnt), 32'(exp_bcast));
            chk("m_data", 32'(m_data), 32'(s_data));
            chk("m_sof", 32'(m_sof), 32'(s_sof));
            chk("m_eof", 32'(m_eof), 32'(s_eof));
        end
    end

    task automatic idle_exp();
        exp_ready  = 1'b1;
        exp_mv     = '0;
        exp_busy   = 1'b0;
        exp_orphan = 1'b0;
    endtask

    task automatic send_frame(
        input int dst, input int src, input int n, input logic [7:0] base,
        input int stall_port, input int stall_n, input int rst_at,
        output int first_acc, output int last_acc,
        output logic [NP-1:0] mv_seen
    );
        logic [NP+1:0] r;
        logic          drop;
        logic          bc;
        logic [NP-1:0] mask;
        logic          acc;
        int            cyc;
        int            i;
        int            stall;
        int            guard;
        r    = route(dst, src);
        drop = r[NP+1];
        bc   = r[NP];
        mask = r[NP-1:0];
        first_acc = -1;
        last_acc  = -1;
        mv_seen   = '0;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_eof   = (n == 1);
        s_data  = base;
        s_dst   = 3'(dst);
        s_src   = 3'(src);
        m_ready = '1;
        exp_ready  = 1'b0;
        exp_mv     = '0;
        exp_busy   = 1'b0;
        exp_orphan = 1'b0;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        if (drop) exp_drop = sat_inc(exp_drop);
        cyc   = 2;
        i     = 0;
        stall = stall_n;
        guard = 0;
        while (i < n && guard < 64) begin
            s_sof  = (i == 0);
            s_eof  = (i == n - 1);
            s_data = 8'(int'(base) + i);
            m_ready = '1;
            if (stall > 0) m_ready[stall_port] = 1'b0;
            exp_mv    = drop ? '0 : mask;
            exp_ready = drop ? 1'b1 : &(m_ready | ~mask);
            acc = exp_ready;
            #1;
            if (s_ready && first_acc < 0) first_acc = cyc;
            if (s_ready) last_acc = cyc;
            if (i == 0 && mv_seen == '0) mv_seen = m_valid;
            if (i == rst_at) begin
                arst_n  = 1'b0;
                s_valid = 1'b0;
                s_sof   = 1'b0;
                s_eof   = 1'b0;
                idle_exp();
                exp_drop  = '0;
                exp_bcast = '0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_s_ready", 32'(s_ready), 32'd1);
                chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
                chk("rst_bcast_cnt", 32'(bcast_cnt), 32'd0);
                @(posedge clk); #3;
                arst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (acc) begin
                i++;
                if (i == n && bc) exp_bcast = sat_inc(exp_bcast);
            end
            if (stall > 0) stall--;
            cyc++;
            guard++;
        end
        if (guard >= 64) begin
            n_chk++;
            n_err++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", i, n);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
        m_ready = '1;
        idle_exp();
        @(posedge clk); #1;
    endtask

    int            fa;
    int            la;
    logic [NP-1:0] mv;

    initial begin
        arst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
        s_dst   = '0;
        s_src   = '0;
        m_ready = '1;
        idle_exp();
        exp_drop  = '0;
        exp_bcast = '0;
        #12;
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_orphan", 32'(orphan), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset_bcast_cnt", 32'(bcast_cnt), 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Unicast to port 2
        send_frame(2, 0, 4, 8'hA0, 0, 0, -1, fa, la, mv);
        chk("uni_mask", 32'(mv), 32'h04);
        chk("uni_sof_cycle", 32'(fa), 32'd2);
        chk("uni_last_cycle", 32'(la), 32'd5);
        chk("uni_drop_cnt", 32'(drop_cnt), 32'd0);

        // Broadcast from port 1, port 3 stalls five cycles
        send_frame(7, 1, 3, 8'hB0, 3, 5, -1, fa, la, mv);
        chk("bc_mask", 32'(mv), 32'h1D);
        chk("bc_sof_cycle", 32'(fa), 32'd7);
        chk("bc_cnt", 32'(bcast_cnt), 32'd1);

        // Broadcast from a non-local source reaches every port
        send_frame(7, 6, 2, 8'hC0, 0, 0, -1, fa, la, mv);
        chk("bc_all_mask", 32'(mv), 32'h1F);
        chk("bc_cnt2", 32'(bcast_cnt), 32'd2);

        // Drops: self-addressed and out-of-range
        send_frame(4, 4, 2, 8'hD0, 0, 0, -1, fa, la, mv);
        chk("drop_self_mv", 32'(mv), 32'd0);
        send_frame(5, 0, 2, 8'hD8, 0, 0, -1, fa, la, mv);
        chk("drop_range_mv", 32'(mv), 32'd0);
        chk("drop_cnt2", 32'(drop_cnt), 32'd2);

        // Orphan beat, then single-beat frame to the CPU
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
        s_data  = 8'h33;
        exp_orphan = 1'b1;
        #1;
        chk("orphan_pulse", 32'(orphan), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_orphan = 1'b0;
        @(posedge clk); #1;
        send_frame(0, 3, 1, 8'h5C, 0, 0, -1, fa, la, mv);
        chk("single_mask", 32'(mv), 32'h01);
        chk("single_acc", 32'(la - fa), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // Reset during beat 2, then a normal frame
        send_frame(1, 2, 4, 8'hE0, 0, 0, 1, fa, la, mv);
        send_frame(1, 2, 2, 8'hF0, 0, 0, -1, fa, la, mv);
        chk("post_rst_mask", 32'(mv), 32'h02);
        chk("post_rst_sof_cycle", 32'(fa), 32'd2);

        // Saturation via preloaded drop counter
        chk_en = 1'b0;
        force dut.drop_cnt_q = 16'hFFFE;
        exp_drop = 16'hFFFE;
        @(posedge clk); #1;
        release dut.drop_cnt_q;
        chk_en = 1'b1;
        send_frame(6, 0, 1, 8'h11, 0, 0, -1, fa, la, mv);
        chk("sat_first", 32'(drop_cnt), 32'hFFFF);
        send_frame(3, 3, 1, 8'h22, 0, 0, -1, fa, la, mv);
        chk("sat_hold", 32'(drop_cnt), 32'hFFFF);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
